// File: rtl/calc_input_ctrl.sv
`default_nettype none
// ============================================================================
// calc_input_ctrl : debounced operand/operation entry front end for the
//                   4-bit calculator. Optional macro: LIVE_OPERATION_EN.
// Revision 1.0
// ============================================================================
module calc_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       btn_next,
   input  logic       btn_clr,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] operation,
   output logic       en,
   output logic [1:0] step
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_A   = 2'd0,
      ST_B   = 2'd1,
      ST_OP  = 2'd2,
      ST_RUN = 2'd3
   } state_t;

   // Bit 0 carries btn_next, bit 1 carries btn_clr.
   logic [1:0] btn_meta, btn_sync;
   logic [3:0] sw_meta, sw_sync;
   logic [1:0] pulse;
   logic       nxt_p, clr_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta <= '0;
         btn_sync <= '0;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         btn_meta <= {btn_clr, btn_next};
         btn_sync <= btn_meta;
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
      end
   end

   generate
      for (genvar i = 0; i < 2; i++) begin : g_db
         logic [CNT_W-1:0] cnt;
         logic             stable;
         logic             stable_d;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt      <= '0;
               stable   <= 1'b0;
               stable_d <= 1'b0;
            end else begin
               stable_d <= stable;
               if (btn_sync[i] == stable) begin
                  cnt <= '0;
               end else if (cnt == CNT_MAX) begin
                  stable <= btn_sync[i];
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         // Both terms are registered, so the pulse is glitch-free.
         assign pulse[i] = stable & ~stable_d;
      end
   endgenerate

   assign nxt_p = pulse[0];
   assign clr_p = pulse[1];

   state_t     state, state_nx;
   logic [3:0] a_nx, b_nx;
   logic [2:0] op_nx;
   logic       en_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_A;
         a         <= '0;
         b         <= '0;
         operation <= '0;
         en        <= 1'b0;
      end else begin
         state     <= state_nx;
         a         <= a_nx;
         b         <= b_nx;
         operation <= op_nx;
         en        <= en_nx;
      end
   end

   always_comb begin
      state_nx = state;
      a_nx     = a;
      b_nx     = b;
      op_nx    = operation;
      en_nx    = en;
      if (clr_p) begin
         // Clear takes priority over a simultaneous next pulse.
         state_nx = ST_A;
         a_nx     = '0;
         b_nx     = '0;
         op_nx    = '0;
         en_nx    = 1'b0;
      end else if (nxt_p) begin
         case (state)
            ST_A: begin
               a_nx     = sw_sync;
               state_nx = ST_B;
            end
            ST_B: begin
               b_nx     = sw_sync;
               state_nx = ST_OP;
            end
            ST_OP: begin
               op_nx    = sw_sync[2:0];
               en_nx    = 1'b1;
               state_nx = ST_RUN;
            end
            default: begin
               en_nx    = 1'b0;
               state_nx = ST_A;
            end
         endcase
      end else begin
`ifdef LIVE_OPERATION_EN
         if (state == ST_RUN) begin
            op_nx = sw_sync[2:0];
         end
`endif
      end
   end

   assign step = state;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_ctrl.sv
`default_nettype none
// ============================================================================
// tb_calc_input_ctrl : scoreboard bench for calc_input_ctrl (DEBOUNCE_CYCLES=4).
// Revision 1.0
// ============================================================================
module tb_calc_input_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw = 4'hF;
   logic       btn_next = 1'b1;
   logic       btn_clr = 1'b1;
   logic [3:0] a, b;
   logic [2:0] operation;
   logic       en;
   logic [1:0] step;

   calc_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .btn_next (btn_next),
      .btn_clr  (btn_clr),
      .a        (a),
      .b        (b),
      .operation(operation),
      .en       (en),
      .step     (step)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [13:0] val;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   bit          mon_on = 1'b0;
   logic [13:0] prev;
   logic [13:0] cur;

   assign cur = {a, b, operation, en, step};

   // Any change of the output bundle must match the next queued expectation,
   // both in value and in the cycle it appears.
   always @(negedge clk) begin
      if (mon_on && (cur !== prev)) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change cyc=%0d got=%h (a,b,op,en,step) required=no change", cyc, cur);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (cur !== e.val || cyc != e.at) begin
               fails++;
               $display("FAIL output_update got=%h@cyc%0d required=%h@cyc%0d", cur, cyc, e.val, e.at);
            end
         end
         prev = cur;
      end
   end

   task automatic chk(string name, logic [7:0] got, logic [7:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic expect_at(int dly, logic [3:0] ea, logic [3:0] eb, logic [2:0] eo,
                            logic ee, logic [1:0] es);
      exp_t e;
      e.at  = cyc + dly;
      e.val = {ea, eb, eo, ee, es};
      q.push_back(e);
   endtask

   task automatic press_start(bit nxt, bit clr);
      @(negedge clk);
      btn_next = nxt;
      btn_clr  = clr;
   endtask

   task automatic press_end(int hold);
      repeat (hold) @(negedge clk);
      btn_next = 1'b0;
      btn_clr  = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      // Reset with switches and both buttons high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      btn_next = 1'b0;
      btn_clr  = 1'b0;
      chk("reset_a",    {4'd0, a},         8'd0);
      chk("reset_b",    {4'd0, b},         8'd0);
      chk("reset_op",   {5'd0, operation}, 8'd0);
      chk("reset_en",   {7'd0, en},        8'd0);
      chk("reset_step", {6'd0, step},      8'd0);
      prev   = cur;
      mon_on = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_reset_quiet", {6'd0, step}, 8'd0);

      // Full entry: 5, 4, op 2 (sw[3] set to prove it is ignored).
      sw = 4'd5;
      press_start(1, 0); expect_at(7, 4'd5, 4'd0, 3'd0, 1'b0, 2'd1); press_end(6);
      sw = 4'd4;
      press_start(1, 0); expect_at(7, 4'd5, 4'd4, 3'd0, 1'b0, 2'd2); press_end(6);
      sw = 4'b1010;
      press_start(1, 0); expect_at(7, 4'd5, 4'd4, 3'd2, 1'b1, 2'd3); press_end(6);
      press_start(1, 0); expect_at(7, 4'd5, 4'd4, 3'd2, 1'b0, 2'd0); press_end(6);

      // Bounce on next must not advance.
      @(negedge clk);
      btn_next = 1'b1; repeat (2) @(negedge clk);
      btn_next = 1'b0; repeat (2) @(negedge clk);
      btn_next = 1'b1; repeat (2) @(negedge clk);
      btn_next = 1'b0; repeat (12) @(negedge clk);
      chk("bounce_step", {6'd0, step}, 8'd0);

      // Clean press then reach OP.
      sw = 4'd9;
      press_start(1, 0); expect_at(7, 4'd9, 4'd4, 3'd2, 1'b0, 2'd1); press_end(6);
      sw = 4'd3;
      press_start(1, 0); expect_at(7, 4'd9, 4'd3, 3'd2, 1'b0, 2'd2); press_end(6);

      // Clear and next together in OP: clear wins.
      sw = 4'd1;
      press_start(1, 1); expect_at(7, 4'd0, 4'd0, 3'd0, 1'b0, 2'd0); press_end(6);

      // Build a=9, b=3, op=1 in RUN.
      sw = 4'd9;
      press_start(1, 0); expect_at(7, 4'd9, 4'd0, 3'd0, 1'b0, 2'd1); press_end(6);
      sw = 4'd3;
      press_start(1, 0); expect_at(7, 4'd9, 4'd3, 3'd0, 1'b0, 2'd2); press_end(6);
      sw = 4'd1;
      press_start(1, 0); expect_at(7, 4'd9, 4'd3, 3'd1, 1'b1, 2'd3); press_end(6);

      // Switch change while running.
      @(negedge clk);
      sw = 4'b0110;
`ifdef LIVE_OPERATION_EN
      expect_at(3, 4'd9, 4'd3, 3'd6, 1'b1, 2'd3);
`endif
      repeat (8) @(negedge clk);
`ifdef LIVE_OPERATION_EN
      chk("run_operation", {5'd0, operation}, 8'd6);
`else
      chk("run_operation", {5'd0, operation}, 8'd1);
`endif

      // Clear in RUN.
      press_start(0, 1); expect_at(7, 4'd0, 4'd0, 3'd0, 1'b0, 2'd0); press_end(6);

      // Long hold yields exactly one advance.
      sw = 4'd7;
      press_start(1, 0); expect_at(7, 4'd7, 4'd0, 3'd0, 1'b0, 2'd1); press_end(20);

      repeat (5) @(negedge clk);
      chk("final_a",    {4'd0, a},    8'd7);
      chk("final_step", {6'd0, step}, 8'd1);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL pending_expectations got=%0d required=0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/calc_input_ctrl.md
Name: calc_input_ctrl

Overview:
- Operand-entry front end for the 4-bit seven-segment calculator.
- Synchronises and debounces two board pushbuttons.
- Steps the user through entering operand a, operand b and the operation code from 4 slide switches.
- Drives the calculator's en/operation/a/b inputs from registers that are stable between button presses.

Parameters:
- DEBOUNCE_CYCLES, 100000, clock cycles a synchronised button level must hold before it is accepted (1 ms at 100 MHz).
- CNT_W, 17, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  4  slide switches holding the value to capture.
- btn_next  input  1  raw pushbutton, asynchronous: advance entry step.
- btn_clr  input  1  raw pushbutton, asynchronous: clear entry.
- a  output  4  registered operand a to calculator.
- b  output  4  registered operand b to calculator.
- operation  output  3  registered operation code to calculator.
- en  output  1  calculator enable; high only in RUN.
- step  output  2  current FSM state for LEDs (0=A, 1=B, 2=OP, 3=RUN).

Behaviour:
- Reset: on clk edge with rst=1:
  - a=0, b=0, operation=0, en=0, step=0 (state A).
  - Synchroniser flops, debounced levels and counters cleared.
  - rst overrides everything, including mid-debounce and mid-state.
- Synchronisation: btn_next, btn_clr and sw each pass through a 2-flop synchroniser; all FSM logic uses only synchronised values.
- Debounce, per button:
  - Counter cleared whenever the synchronised level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
- Edge detect: one-cycle pulse (nxt_p, clr_p) on each 0->1 transition of a stable level. Release generates no pulse.
- Latency: raw press held steady -> pulse = 2 sync cycles + DEBOUNCE_CYCLES cycles. Pulse -> output register update = 1 cycle.
- FSM transitions on nxt_p:
  - A: a<=sw; go to B.
  - B: b<=sw; go to OP.
  - OP: operation<=sw[2:0] (sw[3] ignored); go to RUN; en<=1 on the same edge.
  - RUN: en<=0; go to A; a, b, operation retain their values until overwritten.
- clr_p from any state: a, b, operation <= 0; en <= 0; go to A.
- clr_p and nxt_p in the same cycle: clear wins; nxt is discarded.
- Without a pulse, all outputs hold.
- en: deasserted in A, B and OP; asserted for every cycle in RUN.
- step: equals the registered state encoding; no glitches.
- Holding a button down produces exactly one pulse; no auto-repeat.

Optional Feature:
- Macro: LIVE_OPERATION_EN.
- Defined: while in RUN, operation <= synchronised sw[2:0] every cycle, so the user can change the operation without re-entering operands. a and b stay frozen. Leaving RUN freezes operation at its last value.
- Undefined: operation changes only on the nxt_p pulse in OP, and on clear/reset.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: assert rst for 2 cycles with sw=4'hF and both buttons high -> a=0, b=0, operation=0, en=0, step=0; no pulse within 10 cycles after rst falls while buttons remain low.
- Full entry: press/release next with sw=5, then sw=4, then sw=3'b010 -> a=5, b=4, operation=2, en=1, step=3. Each value is registered exactly 2+4+1 cycles after its press edge. A fourth press -> en=0, step=0, a=5 and b=4 retained.
- Bounce rejection: in state A, toggle btn_next 1,0,1,0 every 2 cycles, then hold 0 -> no pulse, step stays 0. A clean hold of 6+ cycles -> exactly one advance.
- Clear priority: in state OP, press btn_clr and btn_next on the same cycle -> a=b=operation=0, en=0, step=0; step never reaches 3.
- Clear in RUN: with a=9, b=3, operation=1 and en=1, press clr -> all outputs 0 one cycle after the pulse.
- LIVE_OPERATION_EN: in RUN, change sw from 3'b001 to 3'b110 -> operation=6 within 3 cycles, a and b unchanged. Without the macro, operation stays 1.
